// File: rtl/dds_pkg.sv
// Shared constants and state encoding for the DDS phase accumulator.
// Holds default widths, the sweep divider default and the RUN/SWEEP states.
package dds_pkg;

   localparam int ACC_W_DEF     = 24;
   localparam int PHASE_W_DEF   = 14;
   localparam int SWEEP_DIV_DEF = 256;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_SWEEP = 1'b1
   } dds_state_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Sweep divider and saturating FTW stepper for the DDS phase accumulator.
// Ports: clk, rst, en, clear (restart divider), active (sweep running),
//   ftw_cur/step/limit (current FTW, increment, end FTW),
//   tick (divider period elapsed), ftw_step (stepped FTW), done (sweep ends).
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int SWEEP_DIV = SWEEP_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             active,
   input  logic [ACC_W-1:0] ftw_cur,
   input  logic [ACC_W-1:0] step,
   input  logic [ACC_W-1:0] limit,
   output logic             tick,
   output logic [ACC_W-1:0] ftw_step,
   output logic             done
);

   localparam int DIV_W = (SWEEP_DIV > 2) ? $clog2(SWEEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

   logic [DIV_W-1:0] div;
   logic [ACC_W:0]   sum;
   logic             no_move;
   logic             hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (clear) begin
         div <= '0;
      end else if (active && en) begin
         if (div == DIV_LAST)
            div <= '0;
         else
            div <= div + 1'b1;
      end
   end

   assign tick = active & en & (div == DIV_LAST);

   // One extra bit so a step past 2^ACC_W still saturates at limit.
   assign sum     = {1'b0, ftw_cur} + {1'b0, step};
   // A zero step or a limit at/below the current FTW would never converge
   // upward; leave the FTW alone and end the sweep on the first tick.
   assign no_move = (step == '0) | (limit <= ftw_cur);
   assign hit     = (sum >= {1'b0, limit});

   always_comb begin
      ftw_step = ftw_cur;
      if (!no_move)
         ftw_step = hit ? limit : sum[ACC_W-1:0];
   end

   assign done = tick & (no_move | hit);

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: integrates the active FTW, outputs truncated phase
// plus offset, loads new FTWs glitch-free at wrap and runs upward sweeps.
// Ports: clk, rst (async, active-high), en, ftw_in/ftw_valid/ftw_ready,
//   sweep_start/sweep_step/sweep_limit, phase_off, phase_sync,
//   phase (registered), wrap (carry pulse), busy (load pending or sweeping).
module dds_phase_accum
   import dds_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int PHASE_W   = PHASE_W_DEF,
   parameter int SWEEP_DIV = SWEEP_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ACC_W-1:0]   ftw_in,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   input  logic               sweep_start,
   input  logic [ACC_W-1:0]   sweep_step,
   input  logic [ACC_W-1:0]   sweep_limit,
   input  logic [PHASE_W-1:0] phase_off,
   input  logic               phase_sync,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap,
   output logic               busy
);

   dds_state_t       state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [ACC_W-1:0] ftw_act;
   logic [ACC_W-1:0] shadow;
   logic             pending;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             accept;
   logic             apply;
   logic             start;
   logic             sweeping;
   logic             tick;
   logic             done;
   logic [ACC_W-1:0] ftw_sw;

   assign sum   = {1'b0, acc} + {1'b0, ftw_act};
   // A sync cycle discards the add, so its carry is not a real wrap.
   assign carry = en & ~phase_sync & sum[ACC_W];

   always_comb begin
      acc_next = acc;
      if (phase_sync)
         acc_next = '0;
      else if (en)
         acc_next = sum[ACC_W-1:0];
   end

   assign sweeping  = (state == ST_SWEEP);
   assign ftw_ready = ~pending & ~sweeping;
   assign busy      = pending | sweeping;
   assign accept    = ftw_valid & ftw_ready;
   // Without an enable or with a zero FTW no wrap will ever come,
   // so the shadow word is taken straight away.
   assign apply     = pending & (carry | ~en | (ftw_act == '0));
   assign start     = sweep_start & ~sweeping & ~pending & ~accept;

   dds_sweep_ctrl #(
      .ACC_W     (ACC_W),
      .SWEEP_DIV (SWEEP_DIV)
   ) u_sweep (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clear    (start),
      .active   (sweeping),
      .ftw_cur  (ftw_act),
      .step     (sweep_step),
      .limit    (sweep_limit),
      .tick     (tick),
      .ftw_step (ftw_sw),
      .done     (done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         ftw_act <= '0;
         shadow  <= '0;
         pending <= 1'b0;
         state   <= ST_RUN;
         phase   <= '0;
         wrap    <= 1'b0;
      end else begin
         acc   <= acc_next;
         wrap  <= carry;
         phase <= acc_next[ACC_W-1 -: PHASE_W] + phase_off;

         if (accept) begin
            shadow  <= ftw_in;
            pending <= 1'b1;
         end else if (apply) begin
            ftw_act <= shadow;
            pending <= 1'b0;
         end

         unique case (state)
            ST_RUN: begin
               if (start)
                  state <= ST_SWEEP;
            end
            ST_SWEEP: begin
               if (tick) begin
                  ftw_act <= ftw_sw;
                  if (done)
                     state <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum: directed scenarios plus random
// stimulus compared every cycle against an arithmetic reference model.
module tb_dds_phase_accum;

   localparam int ACC_W   = 24;
   localparam int PHASE_W = 14;
   localparam int DIV     = 4;
   localparam longint MOD = 64'h100_0000;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic [ACC_W-1:0]   ftw_in;
   logic               ftw_valid;
   logic               ftw_ready;
   logic               sweep_start;
   logic [ACC_W-1:0]   sweep_step;
   logic [ACC_W-1:0]   sweep_limit;
   logic [PHASE_W-1:0] phase_off;
   logic               phase_sync;
   logic [PHASE_W-1:0] phase;
   logic               wrap;
   logic               busy;

   int n_cmp = 0;
   int n_err = 0;

   longint m_acc, m_ftw, m_shadow;
   bit     m_pend, m_sweep, m_wrap;
   int     m_cnt;
   int unsigned m_phase;

   dds_phase_accum #(
      .ACC_W     (ACC_W),
      .PHASE_W   (PHASE_W),
      .SWEEP_DIV (DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .ftw_in      (ftw_in),
      .ftw_valid   (ftw_valid),
      .ftw_ready   (ftw_ready),
      .sweep_start (sweep_start),
      .sweep_step  (sweep_step),
      .sweep_limit (sweep_limit),
      .phase_off   (phase_off),
      .phase_sync  (phase_sync),
      .phase       (phase),
      .wrap        (wrap),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_ftw = 0; m_shadow = 0;
      m_pend = 0; m_sweep = 0; m_wrap = 0;
      m_cnt = 0; m_phase = 0;
   endtask

   // Reference: one enabled clock of the DDS, in plain integer arithmetic.
   task automatic model_step();
      longint s, nf;
      bit carry, ready, taken, apply, was_sweep;
      s     = m_acc + m_ftw;
      carry = (s >= MOD);
      ready = !m_pend && !m_sweep;
      taken = ftw_valid && ready;
      apply = m_pend && ((en && !phase_sync && carry) || !en || m_ftw == 0);
      if (phase_sync) begin
         m_acc = 0; m_wrap = 0;
      end else if (en) begin
         m_acc = s % MOD; m_wrap = carry;
      end else begin
         m_wrap = 0;
      end
      m_phase = int'(((m_acc / 1024) + longint'(phase_off)) % 16384);
      was_sweep = m_sweep;
      if (was_sweep && en) begin
         m_cnt++;
         if (m_cnt % DIV == 0) begin
            if (sweep_step == 0 || longint'(sweep_limit) <= m_ftw) begin
               m_sweep = 0;
            end else begin
               nf = m_ftw + longint'(sweep_step);
               if (nf >= longint'(sweep_limit)) begin
                  nf = longint'(sweep_limit);
                  m_sweep = 0;
               end
               m_ftw = nf;
            end
         end
      end
      if (!was_sweep && sweep_start && !m_pend && !taken) begin
         m_sweep = 1; m_cnt = 0;
      end
      if (apply) begin
         m_ftw = m_shadow; m_pend = 0;
      end
      if (taken) begin
         m_shadow = longint'(ftw_in); m_pend = 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("phase", 32'(phase), m_phase);
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("ready", 32'(ftw_ready), 32'(!m_pend && !m_sweep));
      chk("busy", 32'(busy), 32'(m_pend || m_sweep));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_phase", 32'(phase), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_ready", 32'(ftw_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_wrap(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!wrap && n < 2000);
      if (!wrap) chk("wrap_timeout", 0, 1);
   endtask

   task automatic load(input logic [ACC_W-1:0] w);
      ftw_in = w;
      ftw_valid = 1'b1;
      tick();
      ftw_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   initial begin
      int n;
      logic [PHASE_W-1:0] p0, d;
      rst = 0; en = 0; ftw_in = 0; ftw_valid = 0;
      sweep_start = 0; sweep_step = 0; sweep_limit = 0;
      phase_off = 0; phase_sync = 0;
      #2;
      do_reset();

      en = 1'b1;
      load(24'h040000);
      chk("t1_busy", 32'(busy), 1);
      wait_wrap(n);
      wait_wrap(n);
      chk("t1_period", 32'(n), 64);
      p0 = phase;
      tick();
      d = phase - p0;
      chk("t1_pstep", 32'(d), 32'h100);

      repeat (10) tick();
      load(24'h080000);
      chk("t2_ready_low", 32'(ftw_ready), 0);
      wait_wrap(n);
      chk("t2_ready_back", 32'(ftw_ready), 1);
      wait_wrap(n);
      chk("t2_period", 32'(n), 32);

      phase_off = 14'h2000;
      phase_sync = 1'b1;
      tick();
      phase_sync = 1'b0;
      chk("t3_off_zero", 32'(phase), 32'h2000);
      repeat (24) tick();
      chk("t3_off_wrap", 32'(phase), 32'h1000);

      phase_off = 0;
      load(24'h010000);
      wait_idle();
      sweep_step = 24'h010000;
      sweep_limit = 24'h035000;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      chk("t4_busy", 32'(busy), 1);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 100);
      chk("t4_len", 32'(n), 12);
      chk("t4_ready", 32'(ftw_ready), 1);

      phase_off = 14'h0123;
      load(24'h100000);
      n = 0;
      while (m_acc + m_ftw < MOD && n < 1000) begin
         tick();
         n++;
      end
      phase_sync = 1'b1;
      tick();
      phase_sync = 1'b0;
      chk("t5_wrap", 32'(wrap), 0);
      chk("t5_phase", 32'(phase), 32'h0123);
      chk("t5_pend", 32'(busy), 1);
      wait_wrap(n);
      chk("t5_applied", 32'(busy), 0);
      wait_wrap(n);
      chk("t5_period", 32'(n), 16);

      phase_off = 0;
      sweep_step = 24'h001000;
      sweep_limit = 24'hFFFFFF;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (5) tick();
      chk("t6_sweeping", 32'(busy), 1);
      do_reset();
      repeat (10) tick();
      chk("t6_sw_stale", 32'(phase), 0);
      load(24'h040000);
      repeat (3) tick();
      load(24'h200000);
      chk("t6_pending", 32'(busy), 1);
      do_reset();
      repeat (10) tick();
      chk("t6_ld_stale", 32'(phase), 0);

      for (int i = 0; i < 4000; i++) begin
         en          = ($urandom % 8) != 0;
         ftw_valid   = ($urandom % 6) == 0;
         ftw_in      = 24'($urandom >> ($urandom % 16));
         sweep_start = ($urandom % 20) == 0;
         sweep_step  = 24'($urandom >> (8 + $urandom % 16));
         sweep_limit = 24'($urandom);
         phase_sync  = ($urandom % 64) == 0;
         if ($urandom % 32 == 0) phase_off = 14'($urandom);
         if ($urandom % 1500 == 0) do_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
